scan_loader: RTL and testbench

- Byte-to-bit configuration loader between the UART receiver/transmitter and the overlay configuration scan chain.
- Parses a framed command stream from UART RX and serialises payload bits onto the chain head, LSB first, with a one-cycle SHIFT_ENABLE per bit.
- Captures the bit leaving the chain tail on every shift and returns it to the host as readback bytes over UART TX.
- Ends every load with an acknowledge byte.

---
 rtl/scan_loader_if.sv | 21 ++
 rtl/scan_loader.sv | 85 ++++++++
 tb/tb_scan_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/scan_loader_if.sv
// scan_loader_if: UART byte streams, scan chain serial pins and status flags of the configuration loader
interface scan_loader_if;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       TX_READY;
  logic       TX_VALID;
  logic [7:0] TX_DATA;
  logic       SHIFT_HEAD;
  logic       SHIFT_TAIL;
  logic       SHIFT_ENABLE;
  logic       BUSY;
  logic       OVERRUN;
  modport master (
    output RX_VALID, RX_DATA, TX_READY, SHIFT_TAIL,
    input  TX_VALID, TX_DATA, SHIFT_HEAD, SHIFT_ENABLE, BUSY, OVERRUN
  );
  modport slave (
    input  RX_VALID, RX_DATA, TX_READY, SHIFT_TAIL,
    output TX_VALID, TX_DATA, SHIFT_HEAD, SHIFT_ENABLE, BUSY, OVERRUN
  );
endinterface

// File: rtl/scan_loader.sv
// scan_loader: parses UART load frames, shifts payload LSB first into the scan chain and returns captured tail bits
module scan_loader #(
  parameter int         LEN_W    = 16,
  parameter logic [7:0] CMD_LOAD = 8'h4C,
  parameter logic [7:0] CMD_PING = 8'h50,
  parameter logic [7:0] RSP_ACK  = 8'h4B,
  parameter logic [7:0] RSP_ERR  = 8'h3F
) (
  input logic SYSCLK,
  input logic SYSRST,
  scan_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, WAIT_BYTE, SHIFT, SEND, GAP} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] rem;
  logic [7:0] len_lo, sh, tx_data;
  logic [2:0] idx;
  logic last, ovr, shift_done;
  logic [15:0] len_in;
  assign len_in = {bus.RX_DATA, len_lo};
  always_ff @(posedge SYSCLK)
    if (!SYSRST) state <= IDLE;
    else state <= nxt;
  // GAP keeps TX_VALID low for one cycle between the last readback byte and the ack
  always_comb begin
    nxt = state;
    shift_done = idx == 3'd7 || rem == LEN_W'(1);
    bus.TX_VALID = state == SEND;
    bus.TX_DATA = tx_data;
    bus.SHIFT_ENABLE = state == SHIFT;
    bus.SHIFT_HEAD = state == SHIFT && sh[idx];
    bus.BUSY = state != IDLE;
    bus.OVERRUN = ovr;
    case (state)
      IDLE:      if (bus.RX_VALID) nxt = bus.RX_DATA == CMD_LOAD ? LEN_LO : SEND;
      LEN_LO:    if (bus.RX_VALID) nxt = LEN_HI;
      LEN_HI:    if (bus.RX_VALID) nxt = len_in == 16'd0 ? SEND : WAIT_BYTE;
      WAIT_BYTE: if (bus.RX_VALID) nxt = SHIFT;
      SHIFT:     if (shift_done) nxt = SEND;
      SEND:      if (bus.TX_READY) nxt = last ? IDLE : rem != '0 ? WAIT_BYTE : GAP;
      GAP:       nxt = SEND;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge SYSCLK) begin
    if (!SYSRST) begin
      rem <= '0;
      len_lo <= '0;
      sh <= '0;
      tx_data <= '0;
      idx <= '0;
      last <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (bus.RX_VALID && (state == SHIFT || state == SEND || state == GAP)) ovr <= 1'b1;
      case (state)
        IDLE: if (bus.RX_VALID) begin
          tx_data <= bus.RX_DATA == CMD_PING ? CMD_PING : RSP_ERR;
          last <= 1'b1;
        end
        LEN_LO: if (bus.RX_VALID) len_lo <= bus.RX_DATA;
        LEN_HI: if (bus.RX_VALID) begin
          rem <= LEN_W'(len_in);
          tx_data <= RSP_ACK;
          last <= len_in == 16'd0;
        end
        WAIT_BYTE: if (bus.RX_VALID) begin
          sh <= bus.RX_DATA;
          tx_data <= '0;
          idx <= '0;
        end
        SHIFT: begin
          tx_data[idx] <= bus.SHIFT_TAIL;
          idx <= idx + 3'd1;
          rem <= rem - LEN_W'(1);
        end
        GAP: begin
          tx_data <= RSP_ACK;
          last <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_loader.sv
// tb_scan_loader: scoreboard bench with a behavioural scan chain model
module tb_scan_loader;
  logic SYSCLK = 1'b0;
  logic SYSRST = 1'b0;
  scan_loader_if bus();
  scan_loader dut (.SYSCLK(SYSCLK), .SYSRST(SYSRST), .bus(bus));
  always #5 SYSCLK = ~SYSCLK;
  int checks = 0, failures = 0, pulses = 0, extra = 0, clen = 8;
  logic [7:0] tx_q[$];
  logic hq[$];
  logic chk_head = 1'b1, pre_en = 1'b0;
  logic [15:0] chain = '0, pre_val = '0;
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // bit clen-1 sits next to the head, bit 0 drives the tail
  assign bus.SHIFT_TAIL = chain[0];
  always @(posedge SYSCLK)
    if (pre_en) chain <= pre_val;
    else if (bus.SHIFT_ENABLE) chain <= (chain >> 1) | (16'(bus.SHIFT_HEAD) << (clen - 1));
  always @(negedge SYSCLK) begin
    if (bus.TX_VALID && bus.TX_READY) begin
      if (tx_q.size() > 0) check("tx_byte", 32'(bus.TX_DATA), 32'(tx_q.pop_front()));
      else extra++;
    end
    if (bus.SHIFT_ENABLE) begin
      pulses++;
      if (chk_head && hq.size() > 0) check("head", 32'(bus.SHIFT_HEAD), 32'(hq.pop_front()));
    end
  end
  task rx(input logic [7:0] b);
    bus.RX_VALID = 1'b1;
    bus.RX_DATA = b;
    @(posedge SYSCLK); #1;
    bus.RX_VALID = 1'b0;
  endtask
  task cycles(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask
  task wait_idle(input string tag);
    for (int i = 0; i < 300 && bus.BUSY; i++) cycles(1);
    check(tag, 32'(bus.BUSY), 0);
    check({tag, "_txq"}, tx_q.size(), 0);
  endtask
  task preload(input int len, input logic [15:0] v);
    clen = len;
    pre_val = v;
    pre_en = 1'b1;
    cycles(1);
    pre_en = 1'b0;
  endtask
  task push_heads(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) hq.push_back(b[i]);
  endtask
  initial begin
    int p0;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA = '0;
    bus.TX_READY = 1'b1;
    cycles(3);
    check("rst_tx_valid", 32'(bus.TX_VALID), 0);
    check("rst_tx_data", 32'(bus.TX_DATA), 0);
    check("rst_shift_en", 32'(bus.SHIFT_ENABLE), 0);
    check("rst_head", 32'(bus.SHIFT_HEAD), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_overrun", 32'(bus.OVERRUN), 0);
    SYSRST = 1'b1;
    cycles(1);
    tx_q.push_back(8'h50);
    rx(8'h50);
    wait_idle("ping");
    p0 = pulses;
    tx_q.push_back(8'h3F);
    rx(8'h11);
    wait_idle("unknown");
    check("unknown_pulses", pulses - p0, 0);
    preload(8, 16'h00A5);
    p0 = pulses;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h4B);
    push_heads(8'h3C, 8);
    rx(8'h4C); rx(8'h08); rx(8'h00); rx(8'h3C);
    wait_idle("load8");
    check("load8_pulses", pulses - p0, 8);
    check("load8_chain", 32'(chain), 32'h3C);
    preload(10, 16'h03FF);
    p0 = pulses;
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h03);
    tx_q.push_back(8'h4B);
    push_heads(8'hFF, 8);
    push_heads(8'h00, 2);
    rx(8'h4C); rx(8'h0A); rx(8'h00); rx(8'hFF);
    cycles(20);
    rx(8'h00);
    wait_idle("load10");
    check("load10_pulses", pulses - p0, 10);
    check("load10_chain", 32'(chain), 32'h0FF);
    check("load10_overrun", 32'(bus.OVERRUN), 0);
    p0 = pulses;
    tx_q.push_back(8'h4B);
    rx(8'h4C); rx(8'h00); rx(8'h00);
    wait_idle("zero");
    check("zero_pulses", pulses - p0, 0);
    bus.TX_READY = 1'b0;
    tx_q.push_back(8'h4B);
    rx(8'h4C); rx(8'h00); rx(8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge SYSCLK);
      check("bp_valid", 32'(bus.TX_VALID), 1);
      check("bp_data", 32'(bus.TX_DATA), 32'h4B);
      cycles(1);
    end
    bus.TX_READY = 1'b1;
    @(negedge SYSCLK);
    check("bp_valid_hs", 32'(bus.TX_VALID), 1);
    cycles(1);
    check("bp_valid_drop", 32'(bus.TX_VALID), 0);
    wait_idle("bp");
    preload(8, 16'h0000);
    p0 = pulses;
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h4B);
    push_heads(8'hAA, 8);
    rx(8'h4C); rx(8'h08); rx(8'h00); rx(8'hAA);
    check("ovr_in_shift", 32'(bus.SHIFT_ENABLE), 1);
    rx(8'h77);
    check("ovr_set", 32'(bus.OVERRUN), 1);
    wait_idle("ovr");
    check("ovr_sticky", 32'(bus.OVERRUN), 1);
    check("ovr_pulses", pulses - p0, 8);
    check("ovr_chain", 32'(chain), 32'hAA);
    chk_head = 1'b0;
    rx(8'h4C); rx(8'h08); rx(8'h00); rx(8'h0F);
    cycles(1);
    check("mid_shift", 32'(bus.SHIFT_ENABLE), 1);
    SYSRST = 1'b0;
    cycles(1);
    check("rst_mid_shift_en", 32'(bus.SHIFT_ENABLE), 0);
    check("rst_mid_busy", 32'(bus.BUSY), 0);
    check("rst_mid_overrun", 32'(bus.OVERRUN), 0);
    check("rst_mid_tx_valid", 32'(bus.TX_VALID), 0);
    SYSRST = 1'b1;
    cycles(5);
    check("tx_extra", extra, 0);
    check("tx_pending", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
